// File: rtl/detector_uart_pkg.sv
// Shared types and defaults for the detector status UART receiver.
// The PARITY state exists only when DETECTOR_UART_PARITY_EN is defined.
package detector_uart_pkg;

    localparam int unsigned ClksPerBitDefault = 10417;
    localparam logic [3:0]  DetHeaderDefault  = 4'hA;

    // Position of each obstacle flag in the status byte's lower nibble.
    localparam int unsigned FrontBit = 3;
    localparam int unsigned BackBit  = 2;
    localparam int unsigned LeftBit  = 1;
    localparam int unsigned RightBit = 0;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef DETECTOR_UART_PARITY_EN
        StParity,
`endif
        StStop
    } rx_state_e;

endpackage

// File: rtl/detector_uart_rx_if.sv
// Serial line and detector status outputs between the simulated device and the receiver.
interface detector_uart_rx_if;

    logic rx;
    logic front_detector;
    logic back_detector;
    logic left_detector;
    logic right_detector;
    logic frame_valid;
    logic frame_error;

    modport master (
        output rx,
        input  front_detector, back_detector, left_detector, right_detector,
        input  frame_valid, frame_error
    );

    modport slave (
        input  rx,
        output front_detector, back_detector, left_detector, right_detector,
        output frame_valid, frame_error
    );

endinterface

// File: rtl/rx_bit_timer.sv
// Bit-period down-counter: a start load aims the first tick at mid start bit,
// later ticks follow every full bit period while the receiver is running.
module rx_bit_timer
    import detector_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic load_half,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] FullBit = CntW'(CLKS_PER_BIT);

    logic [CntW-1:0] cnt_q;

    assign tick = run && (cnt_q == CntW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_half) begin
            cnt_q <= HalfBit;
        end else if (!run) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= FullBit;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

endmodule

// File: rtl/detector_uart_rx.sv
// UART receiver for detector status bytes (header nibble + four obstacle flags).
// Define DETECTOR_UART_PARITY_EN for 8E1 frames; the default build is 8N1.
module detector_uart_rx
    import detector_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault,
    parameter logic [3:0]  DET_HEADER   = DetHeaderDefault
) (
    input  logic               clk,
    input  logic               rst,
    detector_uart_rx_if.slave  bus
);

    rx_state_e  state_q;
    logic       rx_meta_q, rx_sync_q, rx_prev_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic       front_q, back_q, left_q, right_q;
    logic       frame_valid_q, frame_error_q;
    logic       fall_edge, tick, parity_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // A line held low after a bad stop bit produces no edge, so breaks wait here.
    assign fall_edge = rx_prev_q && !rx_sync_q;

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (state_q != StIdle),
        .load_half ((state_q == StIdle) && fall_edge),
        .tick      (tick)
    );

`ifdef DETECTOR_UART_PARITY_EN
    logic parity_ok_q;
    assign parity_ok = parity_ok_q;
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            front_q       <= 1'b0;
            back_q        <= 1'b0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef DETECTOR_UART_PARITY_EN
            parity_ok_q   <= 1'b0;
`endif
        end else begin
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fall_edge) begin
                        state_q   <= StStart;
                        bit_cnt_q <= '0;
                    end
                end
                StStart: begin
                    // A high line at mid start bit is a glitch: drop it silently.
                    if (tick) state_q <= rx_sync_q ? StIdle : StData;
                end
                StData: begin
                    if (tick) begin
                        shreg_q   <= {rx_sync_q, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef DETECTOR_UART_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
`ifdef DETECTOR_UART_PARITY_EN
                StParity: begin
                    if (tick) begin
                        parity_ok_q <= ~(^shreg_q ^ rx_sync_q);
                        state_q     <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (tick) begin
                        state_q <= StIdle;
                        if (rx_sync_q && (shreg_q[7:4] == DET_HEADER) && parity_ok) begin
                            front_q       <= shreg_q[FrontBit];
                            back_q        <= shreg_q[BackBit];
                            left_q        <= shreg_q[LeftBit];
                            right_q       <= shreg_q[RightBit];
                            frame_valid_q <= 1'b1;
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.front_detector = front_q;
    assign bus.back_detector  = back_q;
    assign bus.left_detector  = left_q;
    assign bus.right_detector = right_q;
    assign bus.frame_valid    = frame_valid_q;
    assign bus.frame_error    = frame_error_q;

endmodule

// File: tb/tb_detector_uart_rx.sv
// Self-checking bench for detector_uart_rx at 16 clocks per bit; follows
// DETECTOR_UART_PARITY_EN to add the even-parity bit to each frame.
module tb_detector_uart_rx;

    localparam int unsigned Cpb = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    detector_uart_rx_if bus ();

    detector_uart_rx #(
        .CLKS_PER_BIT (Cpb),
        .DET_HEADER   (4'hA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both_cnt = 0;

    always @(posedge clk) begin
        if (bus.frame_valid) vcnt <= vcnt + 1;
        if (bus.frame_error) ecnt <= ecnt + 1;
        if (bus.frame_valid && bus.frame_error) both_cnt <= both_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_v;
        int         exp_e;
        logic [3:0] exp_flags;  // {front, back, left, right} = byte[3:0] on good frames
    } vec_t;

    vec_t vecs[6];

    function automatic logic [3:0] flags();
        return {bus.front_detector, bus.back_detector, bus.left_detector, bus.right_detector};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (Cpb) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef DETECTOR_UART_PARITY_EN
        drive_bit(^d ^ pflip);
`endif
        drive_bit(stop);
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic stop,
                             input logic pflip, input int exp_v, input int exp_e,
                             input logic [3:0] exp_flags);
        int v0, e0;
        v0 = vcnt;
        e0 = ecnt;
        send_frame(d, stop, pflip);
        bus.rx = 1'b1;
        repeat (6) @(negedge clk);
        check({name, "_valid"}, vcnt - v0, exp_v);
        check({name, "_error"}, ecnt - e0, exp_e);
        check({name, "_flags"}, int'(flags()), int'(exp_flags));
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] af;
        logic       stop, pflip, good, a2_flip;
        logic [3:0] model_flags;
        int         v0, e0;

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 4'b0101};
        vecs[1] = '{8'hAF, 1'b1, 1, 0, 4'b1111};
        vecs[2] = '{8'h53, 1'b1, 0, 1, 4'b1111};
        vecs[3] = '{8'h3C, 1'b1, 0, 1, 4'b1111};
        vecs[4] = '{8'hA0, 1'b1, 1, 0, 4'b0000};
        vecs[5] = '{8'hB7, 1'b1, 0, 1, 4'b0000};

        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_flags", int'(flags()), 0);
        check("reset_valid", int'(bus.frame_valid), 0);
        check("reset_error", int'(bus.frame_error), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_pulses", vcnt + ecnt, 0);

        foreach (vecs[i]) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop, 1'b0,
                      vecs[i].exp_v, vecs[i].exp_e, vecs[i].exp_flags);
        end

        // Load all-ones, then a bad header must leave them untouched.
        run_frame("hdr_setup", 8'hAF, 1'b1, 1'b0, 1, 0, 4'b1111);
        run_frame("bad_header", 8'h53, 1'b1, 1'b0, 0, 1, 4'b1111);

        // Bad stop bit, then the line stays low: no restart until it goes high.
        v0 = vcnt;
        e0 = ecnt;
        send_frame(8'hA0, 1'b0, 1'b0);
        repeat (3 * Cpb) @(negedge clk);
        check("break_valid", vcnt - v0, 0);
        check("break_error", ecnt - e0, 1);
        check("break_flags", int'(flags()), int'(4'b1111));
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        run_frame("after_break", 8'hA6, 1'b1, 1'b0, 1, 0, 4'b0110);

        // Short low glitch on an idle line.
        v0 = vcnt;
        e0 = ecnt;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (3 * Cpb) @(negedge clk);
        check("glitch_pulses", (vcnt - v0) + (ecnt - e0), 0);
        run_frame("after_glitch", 8'hA9, 1'b1, 1'b0, 1, 0, 4'b1001);

        // Back-to-back frames with no idle gap.
        v0 = vcnt;
        e0 = ecnt;
        send_frame(8'hA8, 1'b1, 1'b0);
        send_frame(8'hA1, 1'b1, 1'b0);
        bus.rx = 1'b1;
        repeat (6) @(negedge clk);
        check("b2b_valid", vcnt - v0, 2);
        check("b2b_error", ecnt - e0, 0);
        check("b2b_flags", int'(flags()), int'(4'b0001));

        // Reset in the middle of bit 4 of 8'hAF.
        af = 8'hAF;
        v0 = vcnt;
        e0 = ecnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(af[i]);
        bus.rx = af[4];
        repeat (Cpb / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midframe_rst_flags", int'(flags()), 0);
        check("midframe_rst_pulse", int'(bus.frame_valid) + int'(bus.frame_error), 0);
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (12 * Cpb) @(negedge clk);
        check("midframe_discard", (vcnt - v0) + (ecnt - e0), 0);
`ifdef DETECTOR_UART_PARITY_EN
        a2_flip = 1'b1;
        run_frame("after_rst", 8'hA2, 1'b1, a2_flip, 0, 1, 4'b0000);
        model_flags = 4'b0000;
`else
        a2_flip = 1'b0;
        run_frame("after_rst", 8'hA2, 1'b1, a2_flip, 1, 0, 4'b0010);
        model_flags = 4'b0010;
`endif

        // Random frames against the frame-level rules.
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) d[7:4] = 4'hA;
            stop  = ($urandom_range(0, 7) != 0);
            pflip = 1'b0;
`ifdef DETECTOR_UART_PARITY_EN
            pflip = ($urandom_range(0, 5) == 0);
`endif
            good = stop && (d[7:4] == 4'hA) && !pflip;
            run_frame($sformatf("rand%0d", n), d, stop, pflip, good ? 1 : 0, good ? 0 : 1,
                      good ? d[3:0] : model_flags);
            if (good) model_flags = d[3:0];
        end

        check("valid_error_exclusive", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
